// File: rtl/piano_pkg.sv
// Shared note codes, play modes and FSM state type for the song-learning sequencer.
package piano_pkg;

  localparam int NOTE_CODE_W = 4;

  localparam logic [NOTE_CODE_W-1:0] NOTE_C = 4'd0;
  localparam logic [NOTE_CODE_W-1:0] NOTE_D = 4'd1;
  localparam logic [NOTE_CODE_W-1:0] NOTE_E = 4'd2;
  localparam logic [NOTE_CODE_W-1:0] NOTE_F = 4'd3;
  localparam logic [NOTE_CODE_W-1:0] NOTE_G = 4'd4;
  localparam logic [NOTE_CODE_W-1:0] NOTE_A = 4'd5;
  localparam logic [NOTE_CODE_W-1:0] NOTE_B = 4'd6;

  localparam logic MODE_DEMO  = 1'b0;
  localparam logic MODE_LEARN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GAP      = 2'd1,
    ST_WAIT_KEY = 2'd2,
    ST_PLAY     = 2'd3
  } state_e;

endpackage

// File: rtl/song_table.sv
// Writable song storage: one note code and one duration per entry.
// Synchronous write, two combinational read ports (duration and note).
module song_table
  import piano_pkg::*;
#(
  parameter int NOTE_W   = 4,
  parameter int SONG_LEN = 24,
  parameter int DUR_W    = 27
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [$clog2(SONG_LEN)-1:0] wr_addr,
  input  logic [NOTE_W-1:0]           wr_note,
  input  logic [DUR_W-1:0]            wr_dur,
  input  logic [$clog2(SONG_LEN)-1:0] rd_a_addr,
  output logic [DUR_W-1:0]            rd_a_dur,
  input  logic [$clog2(SONG_LEN)-1:0] rd_b_addr,
  output logic [NOTE_W-1:0]           rd_b_note
);

  localparam int ADDR_W = $clog2(SONG_LEN);

  logic [NOTE_W-1:0] note_mem [SONG_LEN];
  logic [DUR_W-1:0]  dur_mem  [SONG_LEN];
  logic              wr_in_range;
  logic              rd_a_in_range;
  logic              rd_b_in_range;

  // Only non-power-of-two tables have address codes past the last entry.
  generate
    if (SONG_LEN == (1 << ADDR_W)) begin : g_full_range
      assign wr_in_range   = 1'b1;
      assign rd_a_in_range = 1'b1;
      assign rd_b_in_range = 1'b1;
    end else begin : g_partial_range
      assign wr_in_range   = wr_addr   < ADDR_W'(SONG_LEN);
      assign rd_a_in_range = rd_a_addr < ADDR_W'(SONG_LEN);
      assign rd_b_in_range = rd_b_addr < ADDR_W'(SONG_LEN);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      note_mem[wr_addr] <= wr_note;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  assign rd_a_dur  = rd_a_in_range ? dur_mem[rd_a_addr]  : '0;
  assign rd_b_note = rd_b_in_range ? note_mem[rd_b_addr] : '0;

endmodule

// File: rtl/learn_song_seq.sv
// Song player with demo (autoplay) and learn (wait for matching key) modes.
// Optional learn-mode wait timeout is enabled by defining LEARN_TIMEOUT_EN.
module learn_song_seq
  import piano_pkg::*;
#(
  parameter int NOTE_W      = 4,
  parameter int SONG_LEN    = 24,
  parameter int DUR_W       = 27,
  parameter int GAP_CYC     = 50000000,
  parameter int MISS_W      = 8,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        mode,
  input  logic                        key_valid,
  input  logic [NOTE_W-1:0]           key_in,
  input  logic                        wr_en,
  input  logic [$clog2(SONG_LEN)-1:0] wr_addr,
  input  logic [NOTE_W-1:0]           wr_note,
  input  logic [DUR_W-1:0]            wr_dur,
  output logic                        key_on,
  output logic [NOTE_W-1:0]           key_out,
  output logic [$clog2(SONG_LEN)-1:0] note_idx,
  output logic                        busy,
  output logic                        waiting,
  output logic                        hit,
  output logic                        miss,
  output logic                        done,
  output logic [MISS_W-1:0]           miss_cnt
);

  localparam int IDX_W = $clog2(SONG_LEN);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [IDX_W-1:0]  note_idx_q, note_idx_d;
  logic [NOTE_W-1:0] key_out_q, key_out_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              key_on_q, key_on_d;
  logic              busy_q, busy_d;
  logic              waiting_q, waiting_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              done_q, done_d;

  logic              start_ev, advance_ev, hit_ev, miss_ev, done_ev;
  logic              tbl_we;
  logic [IDX_W-1:0]  nxt_addr;
  logic [NOTE_W-1:0] rd_note;
  logic [DUR_W-1:0]  rd_dur;
  logic [DUR_W-1:0]  dur_last;
  logic [CNT_W-1:0]  play_last;

`ifdef LEARN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign tbl_we   = wr_en && !busy_q;
  assign nxt_addr = (state_q == ST_IDLE) ? '0 : note_idx_q + IDX_W'(1);
  // A zero duration still sounds for one cycle.
  assign dur_last  = (rd_dur == '0) ? '0 : rd_dur - DUR_W'(1);
  assign play_last = CNT_W'(dur_last);

  song_table #(
    .NOTE_W  (NOTE_W),
    .SONG_LEN(SONG_LEN),
    .DUR_W   (DUR_W)
  ) u_table (
    .clk      (clk),
    .wr_en    (tbl_we),
    .wr_addr  (wr_addr),
    .wr_note  (wr_note),
    .wr_dur   (wr_dur),
    .rd_a_addr(note_idx_q),
    .rd_a_dur (rd_dur),
    .rd_b_addr(nxt_addr),
    .rd_b_note(rd_note)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      note_idx_q <= '0;
      key_out_q  <= '0;
      miss_cnt_q <= '0;
      key_on_q   <= 1'b0;
      busy_q     <= 1'b0;
      waiting_q  <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LEARN_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      note_idx_q <= note_idx_d;
      key_out_q  <= key_out_d;
      miss_cnt_q <= miss_cnt_d;
      key_on_q   <= key_on_d;
      busy_q     <= busy_d;
      waiting_q  <= waiting_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      done_q     <= done_d;
`ifdef LEARN_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_ev   = 1'b0;
    advance_ev = 1'b0;
    hit_ev     = 1'b0;
    miss_ev    = 1'b0;
    done_ev    = 1'b0;
    // Stop overrides every other event, including a same-cycle start or key.
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_GAP;
            cnt_d    = '0;
            start_ev = 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = (mode_q == MODE_LEARN) ? ST_WAIT_KEY : ST_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_KEY: begin
          if (key_valid && (key_in == key_out_q)) begin
            hit_ev  = 1'b1;
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            miss_ev = key_valid;
`ifdef LEARN_TIMEOUT_EN
            if (wait_cnt_q == TO_LAST) begin
              miss_ev = 1'b1;
              state_d = ST_PLAY;
              cnt_d   = '0;
            end
`endif
          end
        end
        ST_PLAY: begin
          if (cnt_q == play_last) begin
            cnt_d = '0;
            if (note_idx_q == LAST_IDX) begin
              done_ev = 1'b1;
              state_d = ST_IDLE;
            end else begin
              advance_ev = 1'b1;
              state_d    = ST_GAP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef LEARN_TIMEOUT_EN
    // The wait counter restarts on every fresh entry into WAIT_KEY.
    wait_cnt_d = ((state_q == ST_WAIT_KEY) && (state_d == ST_WAIT_KEY))
                 ? wait_cnt_q + TO_W'(1) : '0;
`endif
  end

  always_comb begin
    key_on_d   = (state_d == ST_PLAY);
    busy_d     = (state_d != ST_IDLE);
    waiting_d  = (state_d == ST_WAIT_KEY);
    hit_d      = hit_ev;
    miss_d     = miss_ev;
    done_d     = done_ev;
    mode_d     = mode_q;
    note_idx_d = note_idx_q;
    key_out_d  = key_out_q;
    miss_cnt_d = miss_cnt_q;
    if (start_ev) begin
      mode_d     = mode;
      note_idx_d = '0;
      miss_cnt_d = '0;
      key_out_d  = rd_note;
    end
    if (advance_ev) begin
      note_idx_d = note_idx_q + IDX_W'(1);
      key_out_d  = rd_note;
    end
    if (miss_ev && (miss_cnt_q != {MISS_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + MISS_W'(1);
    end
  end

  assign key_on   = key_on_q;
  assign key_out  = key_out_q;
  assign note_idx = note_idx_q;
  assign busy     = busy_q;
  assign waiting  = waiting_q;
  assign hit      = hit_q;
  assign miss     = miss_q;
  assign done     = done_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_learn_song_seq.sv
// Directed bench for learn_song_seq: SONG_LEN=4, GAP_CYC=3, table {0/5, 4/2, 5/0, 2/1}.
module tb_learn_song_seq;
  import piano_pkg::*;

  localparam int NOTE_W      = 4;
  localparam int SONG_LEN    = 4;
  localparam int DUR_W       = 27;
  localparam int GAP_CYC     = 3;
  localparam int MISS_W      = 2;
  localparam int TIMEOUT_CYC = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              mode = 1'b0;
  logic              key_valid = 1'b0;
  logic [NOTE_W-1:0] key_in = '0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_addr = '0;
  logic [NOTE_W-1:0] wr_note = '0;
  logic [DUR_W-1:0]  wr_dur = '0;

  logic              key_on;
  logic [NOTE_W-1:0] key_out;
  logic [1:0]        note_idx;
  logic              busy;
  logic              waiting;
  logic              hit;
  logic              miss;
  logic              done;
  logic [MISS_W-1:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  learn_song_seq #(
    .NOTE_W     (NOTE_W),
    .SONG_LEN   (SONG_LEN),
    .DUR_W      (DUR_W),
    .GAP_CYC    (GAP_CYC),
    .MISS_W     (MISS_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .key_valid(key_valid),
    .key_in   (key_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_note  (wr_note),
    .wr_dur   (wr_dur),
    .key_on   (key_on),
    .key_out  (key_out),
    .note_idx (note_idx),
    .busy     (busy),
    .waiting  (waiting),
    .hit      (hit),
    .miss     (miss),
    .done     (done),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic start_run(input logic m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [NOTE_W-1:0] n, input int d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_note = n;
    wr_dur  = DUR_W'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic press(input logic [NOTE_W-1:0] k);
    key_valid = 1'b1;
    key_in    = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic stop_now();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_waiting(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (waiting) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_play_idx(input logic [1:0] idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (key_on && note_idx == idx) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({key_on, busy, waiting, hit, miss, done} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", {key_on, busy, waiting, hit, miss, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({key_out, note_idx, miss_cnt} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_values: key_out %0d note_idx %0d miss_cnt %0d expected all 0", key_out, note_idx, miss_cnt);
    end
    write_entry(2'd0, NOTE_C, 5);
    write_entry(2'd1, NOTE_G, 2);
    write_entry(2'd2, NOTE_A, 0);
    write_entry(2'd3, NOTE_E, 1);
  endtask

  task automatic test_demo();
    int gap_len[4];
    int play_len[4];
    logic [NOTE_W-1:0] note_seen[4];
    int exp_play[4] = '{5, 2, 1, 1};
    logic [NOTE_W-1:0] exp_note[4] = '{NOTE_C, NOTE_G, NOTE_A, NOTE_E};
    int n = 0, low = 0, high = 0;
    bit prev_on = 1'b0, done_seen = 1'b0, done_key_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gap_len[i] = -1; play_len[i] = -1; note_seen[i] = '1;
    end
    start_run(MODE_DEMO);
    for (int c = 0; c < 200; c++) begin
      if (key_on) begin
        if (!prev_on && n < 4) begin
          gap_len[n]   = low;
          note_seen[n] = key_out;
        end
        high++;
      end else begin
        if (prev_on) begin
          if (n < 4) play_len[n] = high;
          n++;
          high = 0;
          low  = 0;
        end
        low++;
      end
      if (done) begin
        done_seen   = 1'b1;
        done_key_on = key_on;
        break;
      end
      prev_on = key_on;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gap_len[i] !== GAP_CYC) begin
        errors++;
        $display("[TB] FAIL demo_gap[%0d]: got %0d expected %0d", i, gap_len[i], GAP_CYC);
      end
      checks++;
      if (play_len[i] !== exp_play[i]) begin
        errors++;
        $display("[TB] FAIL demo_play[%0d]: got %0d expected %0d", i, play_len[i], exp_play[i]);
      end
      checks++;
      if (note_seen[i] !== exp_note[i]) begin
        errors++;
        $display("[TB] FAIL demo_note[%0d]: got %0d expected %0d", i, note_seen[i], exp_note[i]);
      end
    end
    checks++;
    if (!done_seen || done_key_on !== 1'b0) begin
      errors++;
      $display("[TB] FAIL demo_done: seen %0d key_on %0d expected seen 1 key_on 0", done_seen, done_key_on);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, miss_cnt} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL demo_after: done %0d busy %0d miss_cnt %0d expected 0 0 0", done, busy, miss_cnt);
    end
  endtask

  task automatic test_learn();
    bit ok;
    logic [NOTE_W-1:0] exp_note[4] = '{NOTE_C, NOTE_G, NOTE_A, NOTE_E};
    start_run(MODE_LEARN);
    wait_waiting(ok);
    checks++;
    if (!ok || key_out !== NOTE_C || key_on !== 1'b0) begin
      errors++;
      $display("[TB] FAIL learn_wait0: ok %0d key_out %0d key_on %0d expected 1 0 0", ok, key_out, key_on);
    end
    press(NOTE_F);
    checks++;
    if ({miss, hit, waiting, miss_cnt} !== 5'b10101) begin
      errors++;
      $display("[TB] FAIL learn_wrong: miss %0d hit %0d waiting %0d miss_cnt %0d expected 1 0 1 1", miss, hit, waiting, miss_cnt);
    end
    press(NOTE_C);
    checks++;
    if ({hit, miss, key_on, waiting, miss_cnt} !== 6'b101001) begin
      errors++;
      $display("[TB] FAIL learn_hit0: hit %0d miss %0d key_on %0d waiting %0d miss_cnt %0d expected 1 0 1 0 1", hit, miss, key_on, waiting, miss_cnt);
    end
    for (int i = 1; i < 4; i++) begin
      wait_waiting(ok);
      checks++;
      if (!ok || key_out !== exp_note[i]) begin
        errors++;
        $display("[TB] FAIL learn_wait[%0d]: ok %0d key_out %0d expected 1 %0d", i, ok, key_out, exp_note[i]);
      end
      press(exp_note[i]);
      checks++;
      if ({hit, miss, key_on} !== 3'b101) begin
        errors++;
        $display("[TB] FAIL learn_hit[%0d]: hit %0d miss %0d key_on %0d expected 1 0 1", i, hit, miss, key_on);
      end
    end
    wait_done(ok);
    checks++;
    if (!ok || miss_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL learn_done: ok %0d miss_cnt %0d expected 1 1", ok, miss_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_stop();
    bit ok;
    int late_done = 0;
    start_run(MODE_DEMO);
    wait_play_idx(2'd1, ok);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (!ok || {key_on, busy, done} !== 3'b000 || note_idx !== 2'd1) begin
      errors++;
      $display("[TB] FAIL stop_play: ok %0d key_on %0d busy %0d done %0d note_idx %0d expected 1 0 0 0 1", ok, key_on, busy, done, note_idx);
    end
    repeat (10) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++;
      $display("[TB] FAIL stop_quiet: got %0d active cycles expected 0", late_done);
    end
    // Restart clears index and miss count left by earlier runs.
    start_run(MODE_LEARN);
    checks++;
    if (note_idx !== 2'd0 || miss_cnt !== 2'd0 || key_out !== NOTE_C || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart: note_idx %0d miss_cnt %0d key_out %0d busy %0d expected 0 0 0 1", note_idx, miss_cnt, key_out, busy);
    end
    wait_waiting(ok);
    press(NOTE_D);
    stop      = 1'b1;
    key_valid = 1'b1;
    key_in    = NOTE_C;
    @(negedge clk);
    stop      = 1'b0;
    key_valid = 1'b0;
    checks++;
    if (!ok || {hit, miss, busy, waiting} !== 4'b0000 || miss_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL stop_key: ok %0d hit %0d miss %0d busy %0d waiting %0d miss_cnt %0d expected 1 0 0 0 0 1", ok, hit, miss, busy, waiting, miss_cnt);
    end
    stop  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_start_idle: busy %0d expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_start_idle2: busy %0d expected 0", busy);
    end
  endtask

  task automatic test_writes();
    bit ok;
    start_run(MODE_DEMO);
    write_entry(2'd2, NOTE_B, 0);
    wait_play_idx(2'd2, ok);
    checks++;
    if (!ok || key_out !== NOTE_A) begin
      errors++;
      $display("[TB] FAIL write_busy: ok %0d key_out %0d expected 1 %0d", ok, key_out, NOTE_A);
    end
    wait_done(ok);
    @(negedge clk);
    write_entry(2'd2, NOTE_B, 0);
    start_run(MODE_DEMO);
    wait_play_idx(2'd2, ok);
    checks++;
    if (!ok || key_out !== NOTE_B) begin
      errors++;
      $display("[TB] FAIL write_idle: ok %0d key_out %0d expected 1 %0d", ok, key_out, NOTE_B);
    end
    wait_done(ok);
    @(negedge clk);
    write_entry(2'd2, NOTE_A, 0);
  endtask

  task automatic test_saturation_reset();
    bit ok;
    logic [MISS_W-1:0] exp_cnt;
    start_run(MODE_LEARN);
    wait_waiting(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL sat_wait: ok %0d expected 1", ok);
    end
    for (int i = 1; i <= 5; i++) begin
      press(NOTE_D);
      exp_cnt = (i > 3) ? 2'd3 : MISS_W'(i);
      checks++;
      if (miss !== 1'b1 || miss_cnt !== exp_cnt) begin
        errors++;
        $display("[TB] FAIL sat_miss[%0d]: miss %0d miss_cnt %0d expected 1 %0d", i, miss, miss_cnt, exp_cnt);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_on, busy, waiting, hit, miss, done, key_out, note_idx, miss_cnt} !== 14'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: busy %0d waiting %0d miss %0d miss_cnt %0d expected all 0", busy, waiting, miss, miss_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int wait_cycles = 0;
    int high = 0;
    int early_miss = 0;
    start_run(MODE_LEARN);
    wait_waiting(ok);
`ifdef LEARN_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      if (!waiting) break;
      if (miss) early_miss++;
      wait_cycles++;
      @(negedge clk);
    end
    checks++;
    if (!ok || wait_cycles !== TIMEOUT_CYC || early_miss !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_len: ok %0d wait %0d early %0d expected 1 %0d 0", ok, wait_cycles, early_miss, TIMEOUT_CYC);
    end
    checks++;
    if ({miss, key_on} !== 2'b11 || miss_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL timeout_miss: miss %0d key_on %0d miss_cnt %0d expected 1 1 1", miss, key_on, miss_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      if (!key_on) break;
      high++;
      @(negedge clk);
    end
    checks++;
    if (high !== 5) begin
      errors++;
      $display("[TB] FAIL timeout_play: got %0d expected 5", high);
    end
`else
    for (int i = 0; i < 25; i++) begin
      if (miss || !waiting) early_miss++;
      wait_cycles++;
      @(negedge clk);
    end
    checks++;
    if (!ok || early_miss !== 0 || waiting !== 1'b1 || miss_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL wait_forever: ok %0d bad %0d waiting %0d miss_cnt %0d expected 1 0 1 0", ok, early_miss, waiting, miss_cnt);
    end
`endif
    stop_now();
  endtask

  initial begin
    test_reset();
    test_demo();
    test_learn();
    test_stop();
    test_writes();
    test_saturation_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/learn_song_seq.md
Name: learn_song_seq

Overview:
- Parametrised successor to the single-song learning player: plays a note table stored in a writable on-chip song table.
- Two modes, latched at start:
  - Demo: autoplay the whole table.
  - Learn: before each note, wait for the player to press the matching key.
- Sits between the keyboard scanner (key_valid/key_in) and the tone generator (key_on/key_out).
- Adds hit/miss reporting to the UI/score display.

Parameters:
- NOTE_W, 4, width of a note code.
- SONG_LEN, 24, number of table entries (≥2).
- DUR_W, 27, width of per-note duration in clk cycles.
- GAP_CYC, 50000000, silent cycles before each note (≥1).
- MISS_W, 8, width of the saturating miss counter.
- TIMEOUT_CYC, 500000000, learn-mode wait limit (used only with LEARN_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins playback from index 0
- stop  in  1  abort playback
- mode  in  1  0=demo, 1=learn; sampled on accepted start
- key_valid  in  1  one-cycle pulse, a key was pressed
- key_in  in  NOTE_W  code of pressed key
- wr_en  in  1  table write strobe
- wr_addr  in  $clog2(SONG_LEN)  table write index
- wr_note  in  NOTE_W  note code to write
- wr_dur  in  DUR_W  duration to write
- key_on  out  1  tone enable
- key_out  out  NOTE_W  current note code
- note_idx  out  $clog2(SONG_LEN)  current table index
- busy  out  1  high in any state except IDLE
- waiting  out  1  high in WAIT_KEY
- hit  out  1  one-cycle pulse, correct key accepted
- miss  out  1  one-cycle pulse, wrong key (or timeout)
- done  out  1  one-cycle pulse, last note finished
- miss_cnt  out  MISS_W  misses since last accepted start

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, latched mode 0. Table contents are not reset.
- Table writes:
  - Synchronous write when wr_en=1 and busy=0.
  - Writes while busy are ignored.
  - wr_addr ≥ SONG_LEN is ignored.
  - Reads are combinational.
- All outputs are registered.
- FSM: IDLE → GAP → (learn: WAIT_KEY) → PLAY → GAP | IDLE.
- IDLE:
  - start=1 → GAP next cycle.
  - On that transition: note_idx=0, miss_cnt=0, mode latched, key_out=table[0].
  - start while busy is ignored.
- GAP:
  - key_on=0, key_out shows the upcoming note.
  - Lasts exactly GAP_CYC cycles.
  - Then → PLAY (demo) or → WAIT_KEY (learn).
- WAIT_KEY:
  - key_valid with key_in==key_out → hit pulse, → PLAY next cycle.
  - key_valid with a mismatched key → miss pulse, miss_cnt+1 (saturates at all-ones), stay in WAIT_KEY.
  - key_valid=0 → hold indefinitely.
- PLAY:
  - key_on=1 for exactly max(dur,1) cycles; dur=0 is treated as 1.
  - Then, if note_idx==SONG_LEN-1: done pulse, key_on=0, → IDLE.
  - Otherwise: note_idx+1, key_out=next note, → GAP.
  - key_valid during GAP/PLAY is ignored (no hit/miss).
- stop:
  - Highest priority after reset.
  - In any busy state → IDLE next cycle; key_on=0, no done pulse.
  - note_idx and miss_cnt hold their values.
- Same-cycle events:
  - stop together with start in IDLE: stop wins, stay IDLE.
  - stop together with key_valid in WAIT_KEY: no hit/miss.
- Mid-operation reset: immediate return to reset values.

Optional Feature:
- Macro LEARN_TIMEOUT_EN.
- Defined:
  - WAIT_KEY carries a wait counter, cleared on every entry.
  - After TIMEOUT_CYC cycles without a correct key: miss pulse, miss_cnt+1, → PLAY (the note is demonstrated).
  - A wrong key does not reset the counter.
- Undefined: no wait counter; WAIT_KEY waits forever; TIMEOUT_CYC is unused.

Decomposition:
- Package piano_pkg holds:
  - note-code constants (C=0, D=1, E=2, F=3, G=4, A=5, B=6);
  - mode constants MODE_DEMO/MODE_LEARN;
  - FSM state enum.
- Sub-module song_table: SONG_LEN×(NOTE_W+DUR_W) register array, synchronous write, combinational read.

Test Plan:
All scenarios use SONG_LEN=4, GAP_CYC=3, table {0/5, 4/2, 5/0, 2/1}.
- Demo run: start, mode=0 → key_on high 5, 2, 1, 1 cycles, each preceded by 3 low cycles; key_out 0, 4, 5, 2; done one pulse; busy falls the next cycle; miss_cnt=0.
- Learn run: mode=1; key_in=3 then 0 at first WAIT_KEY → miss then hit, miss_cnt=1. Correct keys 4, 5, 2 follow → done; miss_cnt=1.
- Stop mid-PLAY of index 1 → next cycle key_on=0, busy=0, note_idx=1, no done. A new start restarts at index 0 with miss_cnt=0.
- Writes: wr_en while busy, addr 2, note 6 → ignored (key_out still 5 at index 2). Same write while idle → replay shows 6.
- Miss saturation: MISS_W=2 with 5 wrong keys → miss_cnt=3. Assert rst_n low mid-WAIT_KEY → all outputs 0 immediately.
- LEARN_TIMEOUT_EN, TIMEOUT_CYC=10: no key → miss after 10 WAIT_KEY cycles, then key_on for 5 cycles.
